// File: rtl/pulse_stretcher_if.sv
// Trigger/abort inputs and stretched-pulse outputs of pulse_stretcher.
interface pulse_stretcher_if #(
    parameter int CW = 8
);
    logic          tick;
    logic [CW-1:0] len;
    logic          retrig;
    logic          clear;
    logic          level;
    logic          done;
    logic          dropped;

    modport master (output tick, len, retrig, clear, input level, done, dropped);
    modport slave  (input tick, len, retrig, clear, output level, done, dropped);
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle ticks into len-cycle pulses, with optional retrigger
// and a forced low holdoff after each pulse.
module pulse_stretcher #(
    parameter int CW      = 8,
    parameter int HOLDOFF = 2
) (
    input  logic              clk,
    input  logic              rst,
    pulse_stretcher_if.slave  bus
);
    // One counter serves both the pulse length and the holdoff count.
    localparam int HW   = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int CNTW = (CW > HW) ? CW : HW;
    localparam logic [CNTW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNTW'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic            level_q, done_q, dropped_q;
    logic            done_nx, dropped_nx;
    logic            len_ok;
    logic [CNTW-1:0] len_load;

    assign len_ok   = (bus.len != '0);
    assign len_load = CNTW'(bus.len) - CNTW'(1);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        done_nx    = 1'b0;
        dropped_nx = 1'b0;
        if (bus.clear) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tick) begin
                        if (len_ok) begin
                            state_nx = HIGH;
                            cnt_nx   = len_load;
                        end else begin
                            dropped_nx = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (bus.tick && bus.retrig && len_ok) begin
                        cnt_nx = len_load;
                    end else begin
                        dropped_nx = bus.tick;
                        if (cnt != '0) begin
                            cnt_nx = cnt - CNTW'(1);
                        end else begin
                            done_nx = 1'b1;
                            if (HOLDOFF > 0) begin
                                state_nx = HOLD;
                                cnt_nx   = HOLD_LOAD;
                            end else begin
                                state_nx = IDLE;
                                cnt_nx   = '0;
                            end
                        end
                    end
                end
                HOLD: begin
                    dropped_nx = bus.tick;
                    if (cnt == '0) begin
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt - CNTW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            level_q   <= (state_nx == HIGH);
            done_q    <= done_nx;
            dropped_q <= dropped_nx;
        end
    end

    assign bus.level   = level_q;
    assign bus.done    = done_q;
    assign bus.dropped = dropped_q;
endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter CW, default 8: width of the length input and the internal counter.
REQ-002 Parameter HOLDOFF, default 2: minimum number of low cycles forced after each pulse (0 allowed).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 tick  input  1  single-cycle trigger request, synchronous to clk.
REQ-006 len  input  CW  requested pulse length in clk cycles, sampled only when a tick is accepted.
REQ-007 retrig  input  1  1 = a tick during an active pulse reloads the length; 0 = such a tick is dropped.
REQ-008 clear  input  1  synchronous abort of any pulse or holdoff in progress.
REQ-009 level  output  1  stretched pulse; registered.
REQ-010 done  output  1  one-cycle strobe marking a pulse's natural end; registered.
REQ-011 dropped  output  1  one-cycle strobe for each ignored tick; registered.

Function
REQ-012 The FSM SHALL have three states: IDLE, HIGH and HOLD; level SHALL be 1 exactly when the state is HIGH.
REQ-013 IDLE, tick=1, len!=0: the block SHALL load the counter with len-1 and go to HIGH.
REQ-014 Latency: a tick accepted in cycle n SHALL drive level high in cycles n+1 through n+len, and low from n+len+1.
REQ-015 IDLE, tick=1, len=0: no pulse SHALL be produced; dropped SHALL pulse in cycle n+1.
REQ-016 HIGH, counter>0: the counter SHALL decrement by 1 per cycle.
REQ-017 HIGH, counter=0, no reloading tick: state SHALL go to HOLD (HOLDOFF>0) or IDLE (HOLDOFF=0), and done SHALL be 1 for exactly the first low cycle.
REQ-018 HIGH, tick=1, retrig=1, len!=0 (including the last high cycle): the counter SHALL reload with len-1 and level SHALL stay high with no gap.
REQ-019 Under REQ-018, level SHALL stay high through cycle m+len for a tick in cycle m, and done SHALL NOT pulse at the superseded end.
REQ-020 HIGH, tick=1, and either retrig=0 or len=0: the tick SHALL be ignored (pulse unaffected) and dropped SHALL pulse in the next cycle.
REQ-021 HOLD: the counter SHALL count HOLDOFF cycles with level low, then go to IDLE.
REQ-022 HOLD: every tick SHALL be dropped (dropped pulses next cycle).
REQ-023 A tick in the first cycle after HOLD SHALL be accepted.
REQ-024 clear=1 in any state SHALL force IDLE and level=0 in the next cycle.
REQ-025 clear=1 SHALL NOT generate done, and a tick in the same cycle SHALL be discarded without a dropped pulse.
REQ-026 The counter SHALL never wrap.
REQ-027 len = 2^CW-1 SHALL give a pulse of exactly 2^CW-1 cycles.
REQ-028 done and dropped SHALL never be high for more than one consecutive cycle per event.
REQ-029 done and dropped MAY both be high in the same cycle.
REQ-030 All outputs SHALL be driven directly from flip-flops (no combinational path from input to output).

Reset
REQ-031 While rst=1, state SHALL be IDLE, counter 0, and level, done and dropped all 0, independent of clk.
REQ-032 Reset asserted mid-pulse or mid-holdoff SHALL end level immediately, with no done strobe.
REQ-033 After rst deasserts, the first tick SHALL be accepted normally.

Verification
REQ-034 Basic pulse: CW=8, HOLDOFF=2, len=5, tick in cycle 10 -> level high cycles 11-15, done in cycle 16, tick in cycle 17 dropped, tick in cycle 18 accepted.
REQ-035 Retrigger on vs off: len=4, tick at 10, second tick at 12 with len=6 -> retrig=1: level high 11-18, single done at 19; retrig=0: level high 11-14, dropped at 13.
REQ-036 Boundaries: len=0 -> no level, dropped 1 cycle. len=1 -> 1-cycle level. len=255 -> 255 cycles, no wrap. HOLDOFF=0, tick on the cycle after level falls -> accepted.
REQ-037 Abort: clear at cycle 13 of a len=10 pulse started at 10 -> level 0 from cycle 14, no done. Tick and clear together -> no pulse, no dropped.
REQ-038 Async reset: rst pulsed mid-pulse, between clock edges -> level 0 before the next edge; normal operation after release.
